// File: rtl/charlieplex_pkg.sv
// Shared types and LED-index helpers for the charlieplex scan controller.
// led_pair is meant for elaboration-time use (constant arguments only).
package charlieplex_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] anode;
        logic [7:0] cathode;
    } led_pair_t;

    function automatic int led_count(input int pins);
        return pins * (pins - 1);
    endfunction

    // LED k lights anode k/(pins-1); the cathode index skips over the anode pin.
    function automatic led_pair_t led_pair(input int k, input int pins);
        int a;
        int r;
        led_pair_t p;
        a = k / (pins - 1);
        r = k % (pins - 1);
        p.anode   = 8'(a);
        p.cathode = 8'((r < a) ? r : r + 1);
        return p;
    endfunction

endpackage

// File: rtl/charlieplex_tick_gen.sv
// PWM tick prescaler: one-cycle tick every DIV cycles, restarted by clr.
module charlieplex_tick_gen #(
    parameter int DIV = 48
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!rst_n || clr || cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == CNT_LAST) && !clr;

endmodule

// File: rtl/charlieplex_scan_ctrl.sv
// Charlieplex scan controller: double-buffered brightness frame, per-LED PWM slots
// separated by all-hi-Z blanking, buffer swap aligned to frame boundaries.
module charlieplex_scan_ctrl
    import charlieplex_pkg::*;
#(
    parameter int CLOCK_FREQ_MHz = 12,
    parameter int TICK_US        = 4,
    parameter int PINS           = 3,
    parameter int PWM_BITS       = 4,
    parameter int BLANK_CYCLES   = 2,
    localparam int LEDS          = led_count(PINS),
    localparam int AW            = $clog2(LEDS)
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                frame_start,
    output logic [PINS-1:0]     pin_oe,
    output logic [PINS-1:0]     pin_out
);

    localparam int DIV = CLOCK_FREQ_MHz * TICK_US;
    localparam int BW  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0]       BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] TICK_LAST  = '1;
    localparam logic [AW-1:0]       K_LAST     = AW'(LEDS - 1);
    localparam logic [AW:0]         ADDR_LIM   = (AW + 1)'(LEDS);

    state_t              state, state_d;
    logic [BW-1:0]       bcnt, bcnt_d;
    logic [PWM_BITS-1:0] tcnt, tcnt_d;
    logic [AW-1:0]       k, k_d;
    logic                sel, pend, pend_d;
    logic                tick, slot_end, swap_d, wr_en;
    logic [PWM_BITS-1:0] lvl;
    logic [PINS-1:0]     oe_d, out_d;
    logic                fs_d, ready_d;

    logic [PWM_BITS-1:0] buf_a [LEDS];
    logic [PWM_BITS-1:0] buf_b [LEDS];
    logic [PINS-1:0]     oe_mask [LEDS];
    logic [PINS-1:0]     an_mask [LEDS];

    for (genvar g = 0; g < LEDS; g++) begin : g_map
        localparam led_pair_t P = led_pair(g, PINS);
        assign an_mask[g] = PINS'(1) << P.anode;
        assign oe_mask[g] = (PINS'(1) << P.anode) | (PINS'(1) << P.cathode);
    end

    charlieplex_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (state == S_BLANK),
        .tick  (tick)
    );

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state       <= S_BLANK;
            bcnt        <= '0;
            tcnt        <= '0;
            k           <= '0;
            sel         <= 1'b0;
            pend        <= 1'b0;
            pin_oe      <= '0;
            pin_out     <= '0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            state       <= state_d;
            bcnt        <= bcnt_d;
            tcnt        <= tcnt_d;
            k           <= k_d;
            sel         <= sel ^ swap_d;
            pend        <= pend_d;
            pin_oe      <= oe_d;
            pin_out     <= out_d;
            frame_start <= fs_d;
            swap_ack    <= swap_d;
            wr_ready    <= ready_d;
        end
    end

    always_comb begin
        state_d  = state;
        bcnt_d   = bcnt;
        tcnt_d   = tcnt;
        k_d      = k;
        slot_end = 1'b0;
        case (state)
            S_BLANK: begin
                if (bcnt == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt + BW'(1);
                end
            end
            S_DRIVE: begin
                if (tick) begin
                    if (tcnt == TICK_LAST) begin
                        slot_end = 1'b1;
                        state_d  = S_BLANK;
                        tcnt_d   = '0;
                        k_d      = (k == K_LAST) ? '0 : k + AW'(1);
                    end else begin
                        tcnt_d = tcnt + PWM_BITS'(1);
                    end
                end
            end
            default: state_d = S_BLANK;
        endcase
    end

    // Outputs are registered from current state, so the pins trail the FSM by one cycle.
    always_comb begin
        lvl   = sel ? buf_b[k] : buf_a[k];
        oe_d  = '0;
        out_d = '0;
        if (state == S_DRIVE && tcnt < lvl) begin
            oe_d  = oe_mask[k];
            out_d = an_mask[k];
        end
        fs_d    = (state == S_BLANK) && (bcnt == '0) && (k == '0);
        swap_d  = slot_end && (k == K_LAST) && pend;
        pend_d  = swap_d ? 1'b0 : (pend | swap_req);
        ready_d = !(pend_d || swap_d);
        wr_en   = wr_valid && wr_ready && ({1'b0, wr_addr} < ADDR_LIM);
    end

    // sel=0: buf_a is front, buf_b is back. A swap refreshes the new back from the new front.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < LEDS; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else if (swap_d) begin
            for (int i = 0; i < LEDS; i++) begin
                if (sel)
                    buf_b[i] <= buf_a[i];
                else
                    buf_a[i] <= buf_b[i];
            end
        end else if (wr_en) begin
            if (sel)
                buf_a[wr_addr] <= wr_level;
            else
                buf_b[wr_addr] <= wr_level;
        end
    end

endmodule

// File: tb/tb_charlieplex_scan_ctrl.sv
// Directed bench for charlieplex_scan_ctrl with 1-cycle ticks: 18-cycle slots, 108-cycle frames.
module tb_charlieplex_scan_ctrl;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_level;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_start;
    logic [2:0] pin_oe;
    logic [2:0] pin_out;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wait;

    // Per-LED drive patterns for PINS=3 (k -> anode/cathode table).
    logic [2:0] OE_TAB [6] = '{3'b011, 3'b101, 3'b011, 3'b110, 3'b101, 3'b110};
    logic [2:0] AN_TAB [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

    always #5 CLK = ~CLK;

    charlieplex_scan_ctrl #(
        .CLOCK_FREQ_MHz (1),
        .TICK_US        (1),
        .PINS           (3),
        .PWM_BITS       (4),
        .BLANK_CYCLES   (2)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_level    (wr_level),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .pin_oe      (pin_oe),
        .pin_out     (pin_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge of a frame_start cycle; walks one frame and ends on the next one.
    task automatic check_frame(input string tag, input int l0, input int l1, input int l2,
                               input int l3, input int l4, input int l5);
        int lv[6];
        logic [5:0] e;
        lv = '{l0, l1, l2, l3, l4, l5};
        chk({tag, "_fs"}, frame_start, 1);
        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < 18; j++) begin
                e = (j >= 2 && (j - 2) < lv[s]) ? {OE_TAB[s], AN_TAB[s]} : 6'b0;
                chk($sformatf("%s_k%0d_c%0d", tag, s, j), {pin_oe, pin_out}, e);
                @(negedge CLK);
            end
        end
        chk({tag, "_period"}, frame_start, 1);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_wait_fs"}, frame_start, 1);
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        while (swap_ack !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ack"}, swap_ack, 1);
    endtask

    task automatic do_write(input int a, input int l);
        wr_valid = 1'b1;
        wr_addr  = 3'(a);
        wr_level = 4'(l);
        chk("wr_ready_at_write", wr_ready, 1);
        @(negedge CLK);
        wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_level = '0;
        swap_req = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pin_oe", pin_oe, 0);
        chk("rst_pin_out", pin_out, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_wr_ready", wr_ready, 1);

        // Blank frame straight out of reset
        rst_n = 1'b1;
        @(negedge CLK);
        chk("first_fs", frame_start, 1);
        check_frame("blank", 0, 0, 0, 0, 0, 0);
        chk("blank_wr_ready", wr_ready, 1);

        // Single LED full brightness
        do_write(3, 15);
        swap_req = 1'b1;
        @(negedge CLK);
        chk("single_pend_ready", wr_ready, 0);
        wait_ack("single", n_wait);
        chk("single_ack_cycle", n_wait, 105);
        chk("single_ack_ready", wr_ready, 0);
        swap_req = 1'b0;
        @(negedge CLK);
        chk("single_ack_pulse", swap_ack, 0);
        chk("single_ready_back", wr_ready, 1);
        check_frame("single", 0, 0, 0, 15, 0, 0);

        // Back-buffer writes stay hidden until a swap
        do_write(0, 1);
        do_write(5, 8);
        wait_frame("hidden");
        check_frame("hidden", 0, 0, 0, 15, 0, 0);

        // Mid-frame swap with a same-cycle write and a stalled write
        repeat (40) @(negedge CLK);
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_level = 4'd5;
        swap_req = 1'b1;
        chk("hs_ready_at_req", wr_ready, 1);
        @(negedge CLK);
        chk("hs_ready_low", wr_ready, 0);
        wr_addr  = 3'd1;
        wr_level = 4'd9;
        wait_ack("hs", n_wait);
        chk("hs_ack_cycle", n_wait, 66);
        chk("hs_ack_ready", wr_ready, 0);
        wr_valid = 1'b0;
        swap_req = 1'b0;
        @(negedge CLK);
        chk("hs_ack_pulse", swap_ack, 0);
        chk("hs_ready_back", wr_ready, 1);
        check_frame("pwm", 1, 0, 5, 15, 0, 8);

        // Out-of-range writes, then swap_req held past the ack re-requests
        do_write(6, 15);
        do_write(7, 15);
        swap_req = 1'b1;
        @(negedge CLK);
        wait_ack("oor", n_wait);
        @(negedge CLK);
        chk("rereq_fs", frame_start, 1);
        chk("rereq_ack_low", swap_ack, 0);
        chk("rereq_ready", wr_ready, 0);
        swap_req = 1'b0;
        wait_ack("rereq", n_wait);
        chk("rereq_ack_cycle", n_wait, 107);
        @(negedge CLK);
        chk("rereq_ready_back", wr_ready, 1);
        check_frame("oor", 1, 0, 5, 15, 0, 8);

        // Reset during the lit part of slot 2 with a swap pending
        do_write(4, 15);
        swap_req = 1'b1;
        @(negedge CLK);
        chk("mid_pend_ready", wr_ready, 0);
        repeat (36) @(negedge CLK);
        chk("mid_lit", {pin_oe, pin_out}, {3'b011, 3'b010});
        rst_n = 1'b0;
        @(negedge CLK);
        chk("mid_rst_oe", pin_oe, 0);
        chk("mid_rst_out", pin_out, 0);
        chk("mid_rst_ack", swap_ack, 0);
        chk("mid_rst_ready", wr_ready, 1);
        swap_req = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_fs", frame_start, 1);
        check_frame("post_rst", 0, 0, 0, 0, 0, 0);
        chk("post_rst_ready", wr_ready, 1);
        check_frame("post_rst2", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
